// File: rtl/dual_port_ram_p_if.sv
// Bus bundle for dual_port_ram_p: write port, read port, clear request and status.
// The master drives requests; the slave (the RAM) returns read data and status.
interface dual_port_ram_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              re;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              addr_err;

  modport master (
    output clr, we, wr_addr, wr_data, re, rd_addr,
    input  rd_data, rd_valid, busy, addr_err
  );

  modport slave (
    input  clr, we, wr_addr, wr_data, re, rd_addr,
    output rd_data, rd_valid, busy, addr_err
  );
endinterface

// File: rtl/dual_port_ram_p.sv
// Simple dual-port RAM (one write port, one read port) with a registered read
// output and a clear engine that zeroes the array after reset or on request.
// Optional macro RAM_OUTREG_EN adds a second output register stage (2-cycle
// read latency for rd_data, rd_valid and addr_err).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | zeroing mem[cnt] each cycle; user accesses ignored, busy=1
// S_IDLE  | normal operation; user reads/writes accepted, clr starts clear
module dual_port_ram_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  dual_port_ram_p_if.slave   bus
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_fire;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  assign idle    = (state_q == S_IDLE);
  assign wr_ok   = ({1'b0, bus.wr_addr} < DEPTH_X);
  assign rd_ok   = ({1'b0, bus.rd_addr} < DEPTH_X);
  assign wr_fire = idle & bus.we & wr_ok;

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: walk the counter up to DEPTH-1 while clearing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        if (bus.clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage array: the clear engine owns the write port while not idle.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read result selection: write-first bypass, zero for out-of-range reads.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    if (idle) begin
      rd_valid_d = bus.re;
      addr_err_d = (bus.we & ~wr_ok) | (bus.re & ~rd_ok);
      if (bus.re) begin
        if (!rd_ok) begin
          rd_data_d = '0;
        end else if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
          rd_data_d = bus.wr_data;
        end else begin
          rd_data_d = mem[bus.rd_addr];
        end
      end
    end
  end

  // First output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DATA_W-1:0] rd_data_q2;
  logic              rd_valid_q2;
  logic              addr_err_q2;

  // Second output stage follows the first unconditionally, so it drains
  // into the first clear cycle and holds rd_data afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q2  <= '0;
      rd_valid_q2 <= 1'b0;
      addr_err_q2 <= 1'b0;
    end else begin
      rd_data_q2  <= rd_data_q;
      rd_valid_q2 <= rd_valid_q;
      addr_err_q2 <= addr_err_q;
    end
  end

  assign bus.rd_data  = rd_data_q2;
  assign bus.rd_valid = rd_valid_q2;
  assign bus.addr_err = addr_err_q2;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;
`endif

  assign bus.busy = ~idle;

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Bench for dual_port_ram_p: two instances (DEPTH=16 and DEPTH=12) driven with
// identical stimulus and checked every cycle against a behavioural model.
module tb_dual_port_ram_p;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_p_if #(.DATA_W(8), .ADDR_W(4)) if16 ();
  dual_port_ram_p_if #(.DATA_W(8), .ADDR_W(4)) if12 ();

  dual_port_ram_p #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) u_ram16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  dual_port_ram_p #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_ram12 (
    .clk (clk),
    .rst (rst),
    .bus (if12.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // current stimulus
  bit         c_clr, c_we, c_re;
  logic [3:0] c_wa, c_ra;
  logic [7:0] c_wd;

  // model state, index 0 = DEPTH 16, index 1 = DEPTH 12
  int         dep [2] = '{16, 12};
  logic [7:0] mem [2][16];
  int         clear_left [2];
  logic [7:0] s1_d [2];
  bit         s1_v [2];
  bit         s1_e [2];
  logic [7:0] o_d [2];
  bit         o_v [2];
  bit         o_e [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      clear_left[d] = dep[d];
      s1_d[d] = 8'h00; s1_v[d] = 1'b0; s1_e[d] = 1'b0;
      o_d[d]  = 8'h00; o_v[d]  = 1'b0; o_e[d]  = 1'b0;
      for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
    end
  endtask

  task automatic model_edge();
    bit wr_ok, rd_ok;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
`ifdef RAM_OUTREG_EN
      o_d[d] = s1_d[d]; o_v[d] = s1_v[d]; o_e[d] = s1_e[d];
`endif
      if (clear_left[d] > 0) begin
        clear_left[d]--;
        s1_v[d] = 1'b0;
        s1_e[d] = 1'b0;
      end else begin
        wr_ok = int'(c_wa) < dep[d];
        rd_ok = int'(c_ra) < dep[d];
        s1_v[d] = c_re;
        s1_e[d] = (c_we && !wr_ok) || (c_re && !rd_ok);
        if (c_re) begin
          if (!rd_ok) s1_d[d] = 8'h00;
          else if (c_we && wr_ok && c_wa == c_ra) s1_d[d] = c_wd;
          else s1_d[d] = mem[d][c_ra];
        end
        if (c_we && wr_ok) mem[d][c_wa] = c_wd;
        if (c_clr) begin
          clear_left[d] = dep[d];
          for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
        end
      end
`ifndef RAM_OUTREG_EN
      o_d[d] = s1_d[d]; o_v[d] = s1_v[d]; o_e[d] = s1_e[d];
`endif
    end
  endtask

  task automatic compare();
    chk("busy16",  if16.busy,     clear_left[0] > 0);
    chk("valid16", if16.rd_valid, o_v[0]);
    chk("err16",   if16.addr_err, o_e[0]);
    chk("data16",  if16.rd_data,  o_d[0]);
    chk("busy12",  if12.busy,     clear_left[1] > 0);
    chk("valid12", if12.rd_valid, o_v[1]);
    chk("err12",   if12.addr_err, o_e[1]);
    chk("data12",  if12.rd_data,  o_d[1]);
  endtask

  task automatic drive(input bit cl, input bit w, input logic [3:0] wa,
                       input logic [7:0] wd, input bit r, input logic [3:0] ra);
    c_clr = cl; c_we = w; c_wa = wa; c_wd = wd; c_re = r; c_ra = ra;
    if16.clr = cl; if16.we = w; if16.wr_addr = wa; if16.wr_data = wd;
    if16.re = r;   if16.rd_addr = ra;
    if12.clr = cl; if12.we = w; if12.wr_addr = wa; if12.wr_data = wd;
    if12.re = r;   if12.rd_addr = ra;
  endtask

  task automatic cyc(input bit cl, input bit w, input logic [3:0] wa,
                     input logic [7:0] wd, input bit r, input logic [3:0] ra);
    drive(cl, w, wa, wd, r, ra);
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
  endtask

  task automatic rand_cyc(input bit allow_clr);
    bit cl;
    cl = allow_clr && ($urandom_range(0, 49) == 0);
    cyc(cl, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    model_reset();
    #1;
    compare();

    // reset for two cycles, then the power-up clear
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(20);

    // everything reads back zero
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(a));
    idle_cycles(2);

    // write then read
    cyc(1'b0, 1'b1, 4'd5, 8'h0F, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'd5);
    idle_cycles(2);

    // same-cycle write/read, write-first
    cyc(1'b0, 1'b1, 4'd3, 8'hA5, 1'b1, 4'd3);
    idle_cycles(2);

    // fill, clear with random traffic ignored, read back
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b1, 4'(a), 8'(a * 17), 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) rand_cyc(1'b0);
    idle_cycles(2);
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(a));
    idle_cycles(2);

    // out-of-range accesses (only the DEPTH=12 instance)
    cyc(1'b0, 1'b1, 4'd13, 8'h77, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'd13);
    cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'd1);
    cyc(1'b0, 1'b1, 4'd14, 8'h55, 1'b1, 4'd15);
    idle_cycles(2);

    // random traffic with occasional clears
    for (int i = 0; i < 800; i++) rand_cyc(1'b1);
    idle_cycles(20);

    // async reset mid-clear, at counter 7 of the DEPTH=16 instance
    cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'd9);
    cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    idle_cycles(7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    compare();
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(20);
    for (int i = 0; i < 100; i++) rand_cyc(1'b1);
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_p.md
Name: dual_port_ram_p

Overview:
- Parametrised simple dual-port RAM. It has one write port and one independent read port, with separate unidirectional data buses instead of a shared tri-state bus.
- Read output is registered and qualified by rd_valid.
- A built-in clear engine zeroes the whole array after reset or on request, and signals busy while it runs.
- Used as the general storage primitive for buffers and lookup tables in the datapath.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  one-cycle request to start a full-array clear.
- we  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- re  input  1  read enable.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  high for one cycle when rd_data holds a new read result.
- busy  output  1  clear engine active; user accesses are ignored.
- addr_err  output  1  one-cycle pulse when an accepted access has an address >= DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_data=0, rd_valid=0, addr_err=0, busy=1.
  - FSM goes to CLEAR with the clear counter at 0.
  - The array itself is not reset asynchronously; it is zeroed by the clear engine.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt=DEPTH-1 has been written, go to IDLE on the next edge.
  - busy=1 for exactly DEPTH cycles after rst is released.
- IDLE:
  - busy=0 and user accesses are accepted.
  - clr=1 goes to CLEAR with cnt=0 on the next edge. Any we/re in the same cycle as clr is still performed, then the clear begins.
- During CLEAR:
  - we, re and clr are ignored; rd_valid stays 0.
  - rd_data holds its last value.
- Write (IDLE, we=1, wr_addr<DEPTH): mem[wr_addr] <= wr_data at the rising edge.
- Read (IDLE, re=1, rd_addr<DEPTH):
  - rd_data is updated at the same edge; data is visible one cycle after re is sampled.
  - rd_valid=1 for that single cycle.
  - Back-to-back reads give one result per cycle.
- Read with re=0: rd_valid=0 and rd_data holds its value.
- Write and read to the same address in the same cycle: write-first, so rd_data returns the new wr_data.
- Write and read to different addresses in the same cycle: both are performed independently.
- Address out of range (>= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - A write is dropped.
  - A read returns rd_data=0 with rd_valid=1.
  - addr_err pulses for one cycle, aligned with the rd_valid timing: the edge after the access.
  - If both ports are out of range in the same cycle, a single addr_err pulse is produced.
- Reset asserted mid-clear or mid-access:
  - Outputs return immediately to their reset values.
  - The clear restarts from 0 after release.
- Address arithmetic: the clear counter is ADDR_W bits wide and compares against DEPTH-1, so it never wraps past DEPTH.

Optional Feature:
- Macro RAM_OUTREG_EN.
- Defined:
  - Adds a second output register stage; read latency becomes 2 cycles.
  - rd_data, rd_valid and addr_err are all delayed by one extra cycle.
  - rst clears both stages.
  - The pipeline still drains during the first cycle of CLEAR.
- Undefined: read latency is 1 cycle, as described above.

Test Plan:
- Release rst after 2 cycles with DEPTH=16 -> busy=1 for exactly 16 cycles then 0; reading addr 0..15 returns 0x00 with rd_valid=1 each.
- Write 0x0F to addr 5, then read addr 5 the next cycle -> rd_data=0x0F and rd_valid=1 one cycle after re (two cycles with RAM_OUTREG_EN).
- Same-cycle we=1, wr_addr=3, wr_data=0xA5 with re=1, rd_addr=3 -> rd_data=0xA5 on the next cycle (write-first).
- Fill addrs 0..15 with value addr*0x11, then pulse clr -> busy=1 for 16 cycles, no rd_valid during that time, then every read returns 0x00.
- DEPTH=12: write 0x77 to addr 13, then read addr 13 -> addr_err pulses on the write and again on the read; rd_data=0x00, and addr 1 (13 mod 12) is unchanged.
- Assert rst=0 mid-clear at cnt=7, release it -> busy=1 for a fresh 16 cycles; rd_valid=0 and rd_data=0 immediately at reset assertion.
